// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side responder with a small register file, oversampled in msoc_clk.
// Define MDIO_BROADCAST_EN to also accept writes addressed to PHYAD 0.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1622,
  parameter int          NUM_REGS     = 16
) (
  input  logic        msoc_clk,
  input  logic        rst_int_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] status_i,
  output logic        wr_stb,
  output logic [4:0]  wr_regad,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic        busy
);
  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PMIN = PW'(PREAMBLE_MIN);
  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP} state_t;
  state_t state;
  logic [4:0] cnt, phyad, regad;
  logic [PW-1:0] pre_cnt;
  logic [15:0] sh, wd, rdata;
  logic [15:0] regs [NUM_REGS];
  logic mdc_m, mdc_s, mdc_q, dio_m, dio_s, rise, fall, op_rd, match, commit, soft_rst;

  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      {mdc_m, mdc_s, mdc_q, dio_m, dio_s} <= '0;
    end else begin
      mdc_m <= mdc;
      mdc_s <= mdc_m;
      mdc_q <= mdc_s;
      dio_m <= mdio_i;
      dio_s <= dio_m;
    end
  end

  assign rise = mdc_s & ~mdc_q;
  assign fall = ~mdc_s & mdc_q;
  assign wd = {sh[14:0], dio_s};
  assign commit = rise && state == WDATA && cnt == 5'd15;
  assign soft_rst = wr_stb && wr_regad == 5'd0 && wr_data[15];
`ifdef MDIO_BROADCAST_EN
  // Broadcast only ever applies to writes, so address 0 never turns the line around
  assign match = op_rd ? (phyad == PHY_ADDR && phyad != 5'd0) : (phyad == PHY_ADDR || phyad == 5'd0);
`else
  assign match = phyad == PHY_ADDR;
`endif

  always_comb begin
    rdata = 16'h0;
    for (int k = 0; k < NUM_REGS; k++) if (regad == k[4:0]) rdata = regs[k];
    rdata = regad == 5'd0 ? {1'b0, regs[0][14:0]} : regad == 5'd1 ? status_i :
            regad == 5'd2 ? PHY_ID1 : regad == 5'd3 ? PHY_ID2 : rdata;
  end

  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= (k == 0) ? 16'h1140 : 16'h0;
    end else if (soft_rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= (k == 0) ? 16'h1140 : 16'h0;
    end else if (commit) begin
      for (int k = 0; k < NUM_REGS; k++) if (regad == k[4:0] && (k == 0 || k > 3)) regs[k] <= wd;
    end
  end

  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
      cnt <= '0;
      pre_cnt <= '0;
      op_rd <= 1'b0;
      phyad <= '0;
      regad <= '0;
      sh <= '0;
      mdio_o <= 1'b0;
      mdio_oe <= 1'b0;
      wr_stb <= 1'b0;
      wr_regad <= '0;
      wr_data <= '0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      frame_err <= 1'b0;
      if (rise) begin
        cnt <= cnt + 5'd1;
        case (state)
          IDLE: begin
            if (dio_s) pre_cnt <= (pre_cnt >= PMIN) ? pre_cnt : pre_cnt + PW'(1);
            else begin
              pre_cnt <= '0;
              if (pre_cnt >= PMIN) begin
                state <= ST;
                busy <= 1'b1;
              end
            end
          end
          ST: begin
            cnt <= '0;
            state <= dio_s ? OP : IDLE;
            busy <= dio_s;
            frame_err <= ~dio_s;
          end
          OP: begin
            if (cnt == 5'd0) op_rd <= dio_s;
            else begin
              cnt <= '0;
              state <= (op_rd != dio_s) ? PHYAD : IDLE;
              frame_err <= op_rd == dio_s;
              busy <= op_rd != dio_s;
            end
          end
          PHYAD: begin
            phyad <= {phyad[3:0], dio_s};
            if (cnt == 5'd4) begin
              cnt <= '0;
              state <= REGAD;
            end
          end
          REGAD: begin
            regad <= {regad[3:0], dio_s};
            if (cnt == 5'd4) begin
              cnt <= '0;
              state <= match ? TA : SKIP;
            end
          end
          TA: begin
            // Reads only count this rise; the turnaround drive happens on the following fall
            if (!op_rd && cnt == 5'd1 && !dio_s) begin
              cnt <= '0;
              state <= WDATA;
            end else if (!op_rd && (cnt != 5'd0 || !dio_s)) begin
              state <= IDLE;
              frame_err <= 1'b1;
              busy <= 1'b0;
            end
          end
          WDATA: begin
            sh <= wd;
            if (cnt == 5'd15) begin
              wr_stb <= 1'b1;
              wr_regad <= regad;
              wr_data <= wd;
              state <= IDLE;
              busy <= 1'b0;
            end
          end
          SKIP: begin
            if (cnt == 5'd17) begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end
          default: cnt <= cnt;
        endcase
      end else if (fall) begin
        if (state == TA && op_rd && cnt == 5'd1) begin
          mdio_oe <= 1'b1;
          mdio_o <= 1'b0;
          sh <= rdata;
          cnt <= '0;
          state <= RDATA;
        end else if (state == RDATA && cnt == 5'd16) begin
          mdio_oe <= 1'b0;
          mdio_o <= 1'b0;
          state <= IDLE;
          busy <= 1'b0;
        end else if (state == RDATA) begin
          mdio_o <= sh[15];
          sh <= {sh[14:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: bit-banged MDIO master driving the responder, checked against a register-map model.
module tb_mdio_responder;
  logic msoc_clk = 1'b0, rst_int_n = 1'b0, mdc = 1'b0, m_out = 1'b1, line;
  logic [15:0] status_i = 16'h0;
  logic mdio_o, mdio_oe, wr_stb, frame_err, busy;
  logic [4:0] wr_regad;
  logic [15:0] wr_data;
  int total = 0, bad = 0;
  int stb_cnt = 0, err_cnt = 0, oe_cyc = 0, busy_cyc = 0, both_cnt = 0;
  logic [4:0] last_regad = '0;
  logic [15:0] last_data = '0;
  logic [15:0] model [32];

  always #5 msoc_clk = ~msoc_clk;
  assign line = mdio_oe ? mdio_o : m_out;

  mdio_responder dut (
    .msoc_clk(msoc_clk), .rst_int_n(rst_int_n), .mdc(mdc), .mdio_i(line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .status_i(status_i), .wr_stb(wr_stb),
    .wr_regad(wr_regad), .wr_data(wr_data), .frame_err(frame_err), .busy(busy)
  );

  always @(negedge msoc_clk) begin
    if (wr_stb) begin
      stb_cnt++;
      last_regad = wr_regad;
      last_data = wr_data;
    end
    if (frame_err) err_cnt++;
    if (mdio_oe) oe_cyc++;
    if (busy) busy_cyc++;
    if (wr_stb && frame_err) both_cnt++;
  end

  function automatic void model_init();
    for (int i = 0; i < 32; i++) model[i] = 16'h0;
    model[0] = 16'h1140;
  endfunction

  function automatic logic wr_accepted(input logic [4:0] phy);
`ifdef MDIO_BROADCAST_EN
    return phy == 5'd1 || phy == 5'd0;
`else
    return phy == 5'd1;
`endif
  endfunction

  function automatic void model_write(input logic [4:0] ra, input logic [15:0] d);
    if (ra == 5'd0 && d[15]) model_init();
    else if (ra == 5'd0 || (ra >= 5'd4 && ra < 5'd16)) model[ra] = d;
  endfunction

  function automatic logic [15:0] exp_read(input logic [4:0] ra);
    if (ra == 5'd0) return {1'b0, model[0][14:0]};
    if (ra == 5'd1) return status_i;
    if (ra == 5'd2) return 16'h0022;
    if (ra == 5'd3) return 16'h1622;
    if (ra >= 5'd16) return 16'h0;
    return model[ra];
  endfunction

  task automatic slot_lo(input logic b);
    mdc = 1'b0;
    m_out = b;
    repeat ($urandom_range(7, 5)) @(posedge msoc_clk);
    #1;
  endtask

  task automatic slot_hi();
    mdc = 1'b1;
    repeat ($urandom_range(7, 4)) @(posedge msoc_clk);
    #1;
  endtask

  // Full frame from the master side; rst_slot >= 0 asserts reset inside that response slot and returns.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int rst_slot,
                       output logic [15:0] rd, output int oe_bits, output logic ta_ok);
    logic [13:0] hdr;
    logic b;
    hdr = {2'b01, op, phy, ra};
    rd = '0;
    oe_bits = 0;
    ta_ok = 1'b1;
    for (int i = 0; i < pre; i++) begin
      slot_lo(1'b1);
      slot_hi();
    end
    for (int i = 13; i >= 0; i--) begin
      slot_lo(hdr[4'(i)]);
      slot_hi();
    end
    for (int i = 0; i < 18; i++) begin
      b = (op != 2'b01) ? 1'b1 : (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : wd[4'(17 - i)];
      slot_lo(b);
      if (mdio_oe) oe_bits++;
      if (i == 0 && mdio_oe) ta_ok = 1'b0;
      if (i == 1 && !(mdio_oe && !mdio_o)) ta_ok = 1'b0;
      if (i >= 2) rd = {rd[14:0], line};
      if (i == rst_slot) begin
        rst_int_n = 1'b0;
        return;
      end
      slot_hi();
    end
    slot_lo(1'b0);
    slot_hi();
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra,
                         output logic [15:0] rd, output int oe_bits, output logic ta_ok);
    frame(32, 2'b10, phy, ra, 16'h0, -1, rd, oe_bits, ta_ok);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    logic [15:0] rd;
    int ob;
    logic tk;
    frame(32, 2'b01, phy, ra, d, -1, rd, ob, tk);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    int ob;
    logic tk;
    rst_int_n = 1'b0;
    repeat (4) @(posedge msoc_clk);
    #1;
    total++;
    if ({mdio_o, mdio_oe, wr_stb, frame_err, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mdio_o, mdio_oe, wr_stb, frame_err, busy});
    end
    total++;
    if (wr_regad !== 5'd0 || wr_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_wr got=%h/%h exp=00/0000", wr_regad, wr_data);
    end
    rst_int_n = 1'b1;
    model_init();
    repeat (2) @(posedge msoc_clk);
    #1;
    do_read(5'd1, 5'd0, rd, ob, tk);
    total++;
    if (rd !== 16'h1140) begin
      bad++;
      $display("FAIL reset_reg0 got=%h exp=1140", rd);
    end
    do_read(5'd1, 5'd4, rd, ob, tk);
    total++;
    if (rd !== exp_read(5'd4)) begin
      bad++;
      $display("FAIL reset_reg4 got=%h exp=%h", rd, exp_read(5'd4));
    end
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    int ob, s0, b0;
    logic tk;
    s0 = stb_cnt;
    b0 = busy_cyc;
    do_write(5'd1, 5'd4, 16'hA5C3);
    model_write(5'd4, 16'hA5C3);
    total++;
    if (stb_cnt - s0 != 1) begin
      bad++;
      $display("FAIL wr_stb_pulses got=%0d exp=1", stb_cnt - s0);
    end
    total++;
    if (last_regad !== 5'd4 || last_data !== 16'hA5C3) begin
      bad++;
      $display("FAIL wr_fields got=%h/%h exp=04/a5c3", last_regad, last_data);
    end
    total++;
    if (busy_cyc == b0) begin
      bad++;
      $display("FAIL busy_frame got=0 exp=nonzero");
    end
    do_read(5'd1, 5'd4, rd, ob, tk);
    total++;
    if (rd !== exp_read(5'd4)) begin
      bad++;
      $display("FAIL rd_reg4 got=%h exp=%h", rd, exp_read(5'd4));
    end
    total++;
    if (ob != 17 || tk !== 1'b1) begin
      bad++;
      $display("FAIL rd_oe_window got=%0d/%b exp=17/1", ob, tk);
    end
    total++;
    if (busy !== 1'b0 || mdio_oe !== 1'b0) begin
      bad++;
      $display("FAIL rd_end got=%b%b exp=00", busy, mdio_oe);
    end
  endtask

  task automatic test_id_status();
    logic [15:0] rd;
    int ob;
    logic tk;
    logic [4:0] ras [4] = '{5'd2, 5'd3, 5'd1, 5'd20};
    status_i = 16'h796D;
    for (int i = 0; i < 4; i++) begin
      do_read(5'd1, ras[i], rd, ob, tk);
      total++;
      if (rd !== exp_read(ras[i]) || ob != 17) begin
        bad++;
        $display("FAIL id_status reg=%0d got=%h/%0d exp=%h/17", ras[i], rd, ob, exp_read(ras[i]));
      end
    end
  endtask

  task automatic test_preamble();
    logic [15:0] rd;
    int ob, o0, e0, b0;
    logic tk;
    o0 = oe_cyc;
    e0 = err_cnt;
    b0 = busy_cyc;
    frame(31, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, ob, tk);
    total++;
    if (oe_cyc != o0 || err_cnt != e0 || busy_cyc != b0) begin
      bad++;
      $display("FAIL short_preamble got=oe%0d err%0d busy%0d exp=0/0/0", oe_cyc - o0, err_cnt - e0, busy_cyc - b0);
    end
    e0 = err_cnt;
    o0 = oe_cyc;
    frame(32, 2'b11, 5'd1, 5'd4, 16'h0, -1, rd, ob, tk);
    total++;
    if (err_cnt - e0 != 1 || oe_cyc != o0) begin
      bad++;
      $display("FAIL bad_op got=err%0d oe%0d exp=1/0", err_cnt - e0, oe_cyc - o0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_op_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_mismatch();
    logic [15:0] rd;
    int ob, s0, o0, e0;
    logic tk;
    s0 = stb_cnt;
    o0 = oe_cyc;
    e0 = err_cnt;
    do_write(5'd7, 5'd4, 16'hFFFF);
    total++;
    if (stb_cnt != s0) begin
      bad++;
      $display("FAIL mismatch_wr got=%0d exp=0", stb_cnt - s0);
    end
    do_read(5'd7, 5'd4, rd, ob, tk);
    total++;
    if (oe_cyc != o0 || err_cnt != e0) begin
      bad++;
      $display("FAIL mismatch_rd got=oe%0d err%0d exp=0/0", oe_cyc - o0, err_cnt - e0);
    end
    do_read(5'd1, 5'd4, rd, ob, tk);
    total++;
    if (rd !== exp_read(5'd4)) begin
      bad++;
      $display("FAIL mismatch_keep got=%h exp=%h", rd, exp_read(5'd4));
    end
  endtask

  task automatic test_broadcast();
    logic [15:0] rd;
    int ob, s0, o0;
    logic tk;
    s0 = stb_cnt;
    do_write(5'd0, 5'd4, 16'h1234);
    if (wr_accepted(5'd0)) model_write(5'd4, 16'h1234);
    total++;
    if (stb_cnt - s0 != int'(wr_accepted(5'd0))) begin
      bad++;
      $display("FAIL bcast_wr got=%0d exp=%0d", stb_cnt - s0, wr_accepted(5'd0));
    end
    o0 = oe_cyc;
    do_read(5'd0, 5'd4, rd, ob, tk);
    total++;
    if (oe_cyc != o0) begin
      bad++;
      $display("FAIL bcast_rd_oe got=%0d exp=0", oe_cyc - o0);
    end
    do_read(5'd1, 5'd4, rd, ob, tk);
    total++;
    if (rd !== exp_read(5'd4)) begin
      bad++;
      $display("FAIL bcast_reg4 got=%h exp=%h", rd, exp_read(5'd4));
    end
  endtask

  task automatic test_soft_reset();
    logic [15:0] rd;
    int ob;
    logic tk;
    do_write(5'd1, 5'd4, 16'hBEEF);
    model_write(5'd4, 16'hBEEF);
    do_write(5'd1, 5'd0, 16'h8000);
    model_write(5'd0, 16'h8000);
    do_read(5'd1, 5'd0, rd, ob, tk);
    total++;
    if (rd !== 16'h1140) begin
      bad++;
      $display("FAIL soft_rst_reg0 got=%h exp=1140", rd);
    end
    do_read(5'd1, 5'd4, rd, ob, tk);
    total++;
    if (rd !== 16'h0000) begin
      bad++;
      $display("FAIL soft_rst_reg4 got=%h exp=0000", rd);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] rd;
    int ob;
    logic tk;
    do_write(5'd1, 5'd5, 16'h5A5A);
    model_write(5'd5, 16'h5A5A);
    frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 9, rd, ob, tk);
    #1;
    total++;
    if (ob != 9 || mdio_oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_read got=slots%0d oe%b busy%b exp=9/0/0", ob, mdio_oe, busy);
    end
    repeat (3) @(posedge msoc_clk);
    #1;
    rst_int_n = 1'b1;
    model_init();
    do_read(5'd1, 5'd5, rd, ob, tk);
    total++;
    if (rd !== exp_read(5'd5) || ob != 17 || tk !== 1'b1) begin
      bad++;
      $display("FAIL rst_after_read got=%h/%0d/%b exp=%h/17/1", rd, ob, tk, exp_read(5'd5));
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, d;
    logic [4:0] phy, ra;
    int ob, s0, pick;
    logic tk;
    for (int n = 0; n < 16; n++) begin
      pick = $urandom_range(3, 0);
      phy = (pick < 2) ? 5'd1 : (pick == 2) ? 5'd0 : 5'($urandom_range(31, 2));
      ra = ($urandom_range(3, 0) == 0) ? 5'($urandom_range(31, 0)) : 5'($urandom_range(15, 0));
      d = 16'($urandom);
      status_i = 16'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        s0 = stb_cnt;
        do_write(phy, ra, d);
        if (wr_accepted(phy)) model_write(ra, d);
        total++;
        if (stb_cnt - s0 != int'(wr_accepted(phy)) ||
            (wr_accepted(phy) && (last_regad !== ra || last_data !== d))) begin
          bad++;
          $display("FAIL rand_wr phy=%0d reg=%0d got=%0d/%h exp=%0d/%h", phy, ra, stb_cnt - s0, last_data,
                   wr_accepted(phy), d);
        end
      end else begin
        do_read(phy, ra, rd, ob, tk);
        total++;
        if (ob != ((phy == 5'd1) ? 17 : 0) || (phy == 5'd1 && rd !== exp_read(ra))) begin
          bad++;
          $display("FAIL rand_rd phy=%0d reg=%0d got=%h/%0d exp=%h/%0d", phy, ra, rd, ob, exp_read(ra),
                   (phy == 5'd1) ? 17 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_status();
    test_preamble();
    test_mismatch();
    test_broadcast();
    test_soft_reset();
    test_reset_mid_read();
    test_random();
    total++;
    if (both_cnt != 0) begin
      bad++;
      $display("FAIL stb_err_overlap got=%0d exp=0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
